relprime_checker: RTL
=====================

Name: relprime_checker

Overview:
- Consumer-side checker for the relprime datapath: takes the n fed to top_level and the m it produced on out, and independently decides whether m is the correct answer.
- Correct answer: the smallest m ≥ 2 with gcd(n,m) = 1.
- Uses an iterative binary GCD engine (one step per cycle) and a candidate scan over k = 2..m-1.
- Sits beside top_level in simulation/FPGA builds as a self-check.

Parameters:
- WIDTH, 16, operand width of n, m and gcd_out.
- CNT_W, 5, width of the binary-GCD common-power-of-two counter z; must hold WIDTH.

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- n  input  WIDTH  register value given to relprime; captured on an accepted start.
- m  input  WIDTH  claimed result; captured on an accepted start.
- busy  output  1  high while a check is in progress.
- done  output  1  one-cycle pulse when results are valid.
- coprime  output  1  gcd(n,m) == 1.
- minimal  output  1  coprime, and no k in [2, m-1] is coprime to n.
- fault  output  1  illegal operands: n == 0 or m < 2.
- gcd_out  output  WIDTH  gcd(n,m) when fault = 0; 0 when fault = 1.

Behaviour:
- Reset (synchronous, active-high): state = IDLE. busy, done, coprime, minimal, fault = 0; gcd_out = 0; internal registers cleared.
- Reset mid-operation aborts the check with no done pulse.
- IDLE:
  - If start = 1, latch n and m into nr and mr, then go to CHECK.
  - start while busy is ignored; no queueing.
- CHECK (1 cycle): busy = 1.
  - If nr == 0 or mr < 2: set fault = 1, coprime = 0, minimal = 0, gcd_out = 0, go to DONE.
  - Otherwise load a = nr, b = mr, z = 0, phase = PRIMARY, go to GCD.
- GCD: one binary-GCD step per cycle, rules applied in this priority:
  - a == 0: result g = b << z, go to EVAL.
  - b == 0: result g = a << z, go to EVAL.
  - a and b both even: a >>= 1, b >>= 1, z++.
  - only a even: a >>= 1.
  - only b even: b >>= 1.
  - both odd, a ≥ b: a = (a - b) >> 1.
  - both odd, a < b: b = (b - a) >> 1.
  - All arithmetic is unsigned WIDTH-bit. The subtraction never underflows because of the compare.
  - Each GCD completes in ≤ 2*WIDTH + 2 cycles.
- EVAL, PRIMARY phase:
  - gcd_out = g; coprime = (g == 1).
  - If g != 1: minimal = 0, go to DONE.
  - Else if mr == 2: minimal = 1, go to DONE.
  - Else k = 2, phase = SCAN, load a = nr, b = k, go to GCD.
- EVAL, SCAN phase:
  - If g == 1: minimal = 0 and stop scanning early; go to DONE.
  - Else k++. If k == mr, set minimal = 1 and go to DONE; otherwise reload a = nr, b = k and go to GCD.
- DONE (1 cycle): done = 1, busy = 0, next state IDLE.
- busy is high from the cycle after start is accepted through the last cycle before DONE.
- coprime, minimal, fault and gcd_out hold their values after done until the next accepted start. On that start they clear to 0 in the CHECK cycle.
- Worst-case latency from start to done is ≤ 3 + (mr - 1) * (2*WIDTH + 3) cycles.
- start = 1 in the same cycle as done is not accepted. It is accepted on the following IDLE cycle if still high.
- start held high continuously re-triggers a new check each time IDLE is reached.

Test Plan:
- Reset 2 cycles; n=21748, m=3, pulse start -> done once; coprime=1, minimal=1, fault=0, gcd_out=1; busy high between start and done.
- n=21748, m=4 -> coprime=0, minimal=0, gcd_out=4. Then n=21748, m=5 -> coprime=1, minimal=0, gcd_out=1 (scan exits early at k=3).
- n=21784, m=3 -> coprime=1, minimal=1, gcd_out=1. Then n=30, m=7 -> coprime=1, minimal=1, gcd_out=1 (k=2..6 all share a factor with 30).
- n=21748, m=1 -> fault=1, coprime=0, minimal=0, gcd_out=0, done 2 cycles after start. Repeat with n=0, m=3 -> same response.
- Start n=30, m=7. Assert Reset for 1 cycle while busy -> no done pulse; all outputs 0 next cycle. Then a start pulse while busy is ignored, and a fresh start with n=30, m=7 completes normally.
- Hold start high across two checks with n=30, m=7 -> two done pulses separated by at least one IDLE cycle; identical results both times.

Source files
------------

// File: rtl/relprime_checker.sv
// relprime_checker: independently verifies that m is the smallest value >= 2
// that is coprime to n. A binary GCD engine takes one step per cycle.
// It first checks gcd(n,m) and then scans the candidates k = 2..m-1.
module relprime_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             coprime,
  output logic             minimal,
  output logic             fault,
  output logic [WIDTH-1:0] gcd_out
);

  typedef enum logic [2:0] {IDLE, CHECK, GCD, EVAL, DONE} state_t;
  typedef enum logic {PRIMARY, SCAN} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] nr_q, nr_d, mr_q, mr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] k_q, k_d, g_q, g_d;
  logic [WIDTH-1:0] gcdOut_q, gcdOut_d;
  logic [CNT_W-1:0] z_q, z_d;
  logic             coprime_q, coprime_d;
  logic             minimal_q, minimal_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] kInc;

  assign kInc    = k_q + WIDTH'(1);
  assign busy    = (state_q == CHECK) || (state_q == GCD) || (state_q == EVAL);
  assign done    = (state_q == DONE);
  assign coprime = coprime_q;
  assign minimal = minimal_q;
  assign fault   = fault_q;
  assign gcd_out = gcdOut_q;

  // State and datapath registers, cleared by the synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      phase_q   <= PRIMARY;
      nr_q      <= '0;
      mr_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      g_q       <= '0;
      z_q       <= '0;
      gcdOut_q  <= '0;
      coprime_q <= 1'b0;
      minimal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      nr_q      <= nr_d;
      mr_q      <= mr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      g_q       <= g_d;
      z_q       <= z_d;
      gcdOut_q  <= gcdOut_d;
      coprime_q <= coprime_d;
      minimal_q <= minimal_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic: operand check, one binary-GCD step per cycle, and the candidate scan
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    nr_d      = nr_q;
    mr_d      = mr_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    g_d       = g_q;
    z_d       = z_q;
    gcdOut_d  = gcdOut_q;
    coprime_d = coprime_q;
    minimal_d = minimal_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nr_d    = n;
          mr_d    = m;
          state_d = CHECK;
        end
      end
      CHECK: begin
        coprime_d = 1'b0;
        minimal_d = 1'b0;
        gcdOut_d  = '0;
        fault_d   = 1'b0;
        if ((nr_q == '0) || (mr_q < WIDTH'(2))) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = nr_q;
          b_d     = mr_q;
          z_d     = '0;
          phase_d = PRIMARY;
          state_d = GCD;
        end
      end
      GCD: begin
        if (a_q == '0) begin
          g_d     = b_q << z_q;
          state_d = EVAL;
        end else if (b_q == '0) begin
          g_d     = a_q << z_q;
          state_d = EVAL;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          z_d = z_q + CNT_W'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      EVAL: begin
        if (phase_q == PRIMARY) begin
          gcdOut_d  = g_q;
          coprime_d = (g_q == WIDTH'(1));
          if (g_q != WIDTH'(1)) begin
            minimal_d = 1'b0;
            state_d   = DONE;
          end else if (mr_q == WIDTH'(2)) begin
            minimal_d = 1'b1;
            state_d   = DONE;
          end else begin
            k_d     = WIDTH'(2);
            phase_d = SCAN;
            a_d     = nr_q;
            b_d     = WIDTH'(2);
            z_d     = '0;
            state_d = GCD;
          end
        end else begin
          if (g_q == WIDTH'(1)) begin
            minimal_d = 1'b0;
            state_d   = DONE;
          end else begin
            k_d = kInc;
            if (kInc == mr_q) begin
              minimal_d = 1'b1;
              state_d   = DONE;
            end else begin
              a_d     = nr_q;
              b_d     = kInc;
              z_d     = '0;
              state_d = GCD;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
